seq_frac_scaler: RTL and testbench

//   Multi-cycle scaler: Y = round(X * K), K = INT_K + FRAC_K/2^FRAC_BITS (default 28.5).

---
 rtl/seq_frac_scaler.sv | 162 ++++++++++++++++
 tb/tb_seq_frac_scaler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frac_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : seq_frac_scaler
//  Description : Multi-cycle fixed-point scaler Y = round(X * K) using a
//                shift-and-add multiply, then one rounding/saturation cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_frac_scaler #(
    parameter int IN_W      = 6,
    parameter int OUT_W     = 11,
    parameter int INT_K     = 28,
    parameter int FRAC_BITS = 1,
    parameter int FRAC_K    = 1,
    parameter int ROUND     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             ovf
);

    localparam int c_kf        = INT_K * (2 ** FRAC_BITS) + FRAC_K;
    localparam int c_kf_w      = (c_kf < 2) ? 1 : $clog2(c_kf + 1);
    localparam int c_acc_w_raw = IN_W + c_kf_w;
    // Keeps at least one integer bit above the fraction for degenerate K < 1.
    localparam int c_acc_w     = (c_acc_w_raw > FRAC_BITS) ? c_acc_w_raw : FRAC_BITS + 1;
    localparam int c_q_w       = c_acc_w - FRAC_BITS;
    localparam int c_r_w       = c_q_w + 1;
    localparam int c_cnt_w     = (IN_W < 2) ? 1 : $clog2(IN_W);

    localparam logic [c_acc_w-1:0] c_kf_v     = c_acc_w'(c_kf);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(IN_W - 1);

    generate
        if (FRAC_BITS < 1 || FRAC_K < 0 || FRAC_K >= (2 ** FRAC_BITS) ||
            ROUND < 0 || ROUND > 2 || INT_K < 0) begin : g_bad_params
            $error("seq_frac_scaler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_W-1:0]      r_xs;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_q_w-1:0]     w_q;
    logic                 w_inc;
    logic [c_r_w-1:0]     w_r;
    logic [OUT_W-1:0]     w_y_sat;
    logic                 w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_count == c_last_cnt) begin
                    w_state_nxt = S_RND;
                end
            end
            S_RND: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xs    <= '0;
            r_acc   <= '0;
            r_count <= '0;
            y       <= '0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_xs    <= x;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_MUL: begin
                    if (r_xs[0]) begin
                        r_acc <= r_acc + (c_kf_v << r_count);
                    end
                    r_xs    <= r_xs >> 1;
                    r_count <= r_count + c_cnt_w'(1);
                end
                S_RND: begin
                    y   <= w_y_sat;
                    ovf <= w_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_q = r_acc[c_acc_w-1:FRAC_BITS];

    generate
        if (ROUND == 0) begin : g_round_floor
            assign w_inc = 1'b0;
        end else if (ROUND == 1) begin : g_round_ceil
            assign w_inc = |r_acc[FRAC_BITS-1:0];
        end else begin : g_round_half_up
            assign w_inc = r_acc[FRAC_BITS-1];
        end
    endgenerate

    assign w_r = {1'b0, w_q} + c_r_w'(w_inc);

    // Saturation only exists when the rounded value can exceed OUT_W bits.
    generate
        if (c_r_w > OUT_W) begin : g_sat
            assign w_ovf   = |w_r[c_r_w-1:OUT_W];
            assign w_y_sat = w_ovf ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];
        end else begin : g_no_sat
            assign w_ovf   = 1'b0;
            assign w_y_sat = OUT_W'(w_r);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seq_frac_scaler.sv
`default_nettype none
// Bench for seq_frac_scaler: five parameterisations driven in lockstep,
// checked against spec vectors and an arithmetic reference model.
module tb_seq_frac_scaler;

    localparam int N = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [5:0]       x = '0;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     ovf;
    logic [10:0]      y0, y1, y2, y4;
    logic [9:0]       y3;
    logic [10:0]      y_all [N];
    logic [10:0]      cap_y [N];
    logic             cap_o [N];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]          x;
        logic [N-1:0][10:0]  ey;
        logic [N-1:0]        eo;
        int                  hold;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    assign y_all[0] = y0;
    assign y_all[1] = y1;
    assign y_all[2] = y2;
    assign y_all[3] = {1'b0, y3};
    assign y_all[4] = y4;

    seq_frac_scaler #(.ROUND(0)) u_r0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .x(x),
        .out_valid(out_valid[0]), .out_ready(out_ready), .y(y0), .ovf(ovf[0]));
    seq_frac_scaler u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .x(x),
        .out_valid(out_valid[1]), .out_ready(out_ready), .y(y1), .ovf(ovf[1]));
    seq_frac_scaler #(.ROUND(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .x(x),
        .out_valid(out_valid[2]), .out_ready(out_ready), .y(y2), .ovf(ovf[2]));
    seq_frac_scaler #(.OUT_W(10)) u_o10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .x(x),
        .out_valid(out_valid[3]), .out_ready(out_ready), .y(y3), .ovf(ovf[3]));
    seq_frac_scaler #(.FRAC_BITS(2), .FRAC_K(1), .ROUND(2)) u_q2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[4]), .x(x),
        .out_valid(out_valid[4]), .out_ready(out_ready), .y(y4), .ovf(ovf[4]));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact rational product, then floor/ceil/half-up and clamp.
    function automatic void model(input int i, input int xv, output longint ey, output bit eo);
        longint ow, fb, rnd, den, num, r, maxv;
        ow  = (i == 3) ? 10 : 11;
        fb  = (i == 4) ? 2 : 1;
        rnd = (i == 0) ? 0 : ((i == 2 || i == 4) ? 2 : 1);
        den = longint'(1) << fb;
        num = longint'(xv) * (28 * den + 1);
        case (rnd)
            0:       r = num / den;
            1:       r = (num + den - 1) / den;
            default: r = (num + den / 2) / den;
        endcase
        maxv = (longint'(1) << ow) - 1;
        if (r > maxv) begin
            ey = maxv;
            eo = 1'b1;
        end else begin
            ey = r;
            eo = 1'b0;
        end
    endfunction

    function automatic vec_t mk(input int xv, input int e0, input int e1, input int e2,
                                input int e3, input int e4, input bit o3, input int hold);
        vec_t v;
        v.x     = 6'(xv);
        v.ey[0] = 11'(e0);
        v.ey[1] = 11'(e1);
        v.ey[2] = 11'(e2);
        v.ey[3] = 11'(e3);
        v.ey[4] = 11'(e4);
        v.eo    = {1'b0, o3, 3'b000};
        v.hold  = hold;
        return v;
    endfunction

    // One transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
    task automatic do_op(input logic [5:0] xv, input int hold);
        int     lat;
        longint ey;
        bit     eo;
        chk("in_ready_idle", in_ready, 5'h1f);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_busy", in_ready, 0);
        x         = ~xv;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid[0] !== 1'b1 && lat < 20);
        chk("latency", lat, 7);
        chk("out_valid_all", out_valid, 5'h1f);
        for (int i = 0; i < N; i++) begin
            cap_y[i] = y_all[i];
            cap_o[i] = ovf[i];
            model(i, int'(xv), ey, eo);
            chk($sformatf("y_model[%0d] x=%0d", i, xv), cap_y[i], ey);
            chk($sformatf("ovf_model[%0d] x=%0d", i, xv), cap_o[i], eo);
        end
        out_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            x = 6'($urandom_range(0, 63));
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 5'h1f);
            chk("hold_in_ready", in_ready, 0);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("hold_y[%0d]", i), y_all[i], cap_y[i]);
                chk($sformatf("hold_ovf[%0d]", i), ovf[i], cap_o[i]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 5'h1f);
    endtask

    initial begin
        tbl[0] = mk(5,  142,  143,  143,  143,  141, 1'b0, 0);
        tbl[1] = mk(0,  0,    0,    0,    0,    0,   1'b0, 1);
        tbl[2] = mk(63, 1795, 1796, 1796, 1023, 1780, 1'b1, 0);
        tbl[3] = mk(1,  28,   29,   29,   29,   28,  1'b0, 0);
        tbl[4] = mk(35, 997,  998,  998,  998,  989, 1'b0, 2);
        tbl[5] = mk(7,  199,  200,  200,  200,  198, 1'b0, 5);
        tbl[6] = mk(2,  57,   57,   57,   57,   57,  1'b0, 0);

        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 5'h1f);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_y[%0d]", i), y_all[i], 0);
            chk($sformatf("reset_ovf[%0d]", i), ovf[i], 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            do_op(tbl[t].x, tbl[t].hold);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("tbl_y[%0d] x=%0d", i, tbl[t].x), cap_y[i], tbl[t].ey[i]);
                chk($sformatf("tbl_ovf[%0d] x=%0d", i, tbl[t].x), cap_o[i], tbl[t].eo[i]);
            end
        end

        for (int v = 0; v < 64; v++) begin
            do_op(6'(v), 0);
        end

        for (int n = 0; n < 40; n++) begin
            do_op(6'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the third MUL cycle after a nonzero result.
        x        = 6'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_y[%0d]", i), y_all[i], 0);
            chk($sformatf("midrst_ovf[%0d]", i), ovf[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(6'd2, 0);
        chk("after_rst_y", cap_y[1], 57);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
